// File: rtl/freq_ctrl_pkg.sv
// Shared types and BCD helpers for the frequency-setting controller.
package freq_ctrl_pkg;

  localparam int BCD_W          = 4;
  localparam int BCD_MAX_DIGITS = 10;

  typedef enum logic [1:0] {IDLE, APPLY, CONV, PUBLISH} state_t;
  typedef enum logic [2:0] {NONE, INC_F, DEC_F, INC_C, DEC_C} cmd_t;

  // Packed BCD of a binary constant, wide enough for any 32-bit value.
  function automatic logic [BCD_W*BCD_MAX_DIGITS-1:0] to_bcd(input int unsigned value);
    logic [BCD_W*BCD_MAX_DIGITS-1:0] r;
    int unsigned v;
    r = '0;
    v = value;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      r[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [BCD_W*BCD_MAX_DIGITS-1:0] bcd_min(input int unsigned fmin);
    return to_bcd(fmin);
  endfunction

  function automatic logic [BCD_W*BCD_MAX_DIGITS-1:0] bcd_max(input int unsigned fmax);
    return to_bcd(fmax);
  endfunction

  function automatic logic [BCD_W*BCD_MAX_DIGITS-1:0] bcd_rst(input int unsigned frst);
    return to_bcd(frst);
  endfunction

endpackage

// File: rtl/bcd_step_addsub.sv
// Adds or subtracts 10^k to a packed BCD word with digit-wise ripple carry/borrow.
module bcd_step_addsub
  import freq_ctrl_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int IDX_W  = 3
) (
  input  logic [BCD_W*DIGITS-1:0] din,
  input  logic [IDX_W-1:0]        k,
  input  logic                    sub,
  output logic [BCD_W*DIGITS-1:0] result,
  output logic                    ovf
);

  logic             c;
  logic             one;
  logic [BCD_W-1:0] d;
  logic [BCD_W:0]   t;

  always_comb begin
    c      = 1'b0;
    one    = 1'b0;
    d      = '0;
    t      = '0;
    result = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d   = din[i*BCD_W +: BCD_W];
      one = (IDX_W'(i) == k);
      if (!sub) begin
        t = {1'b0, d} + {{BCD_W{1'b0}}, one} + {{BCD_W{1'b0}}, c};
        if (t > (BCD_W+1)'(9)) begin
          result[i*BCD_W +: BCD_W] = BCD_W'(t - (BCD_W+1)'(10));
          c = 1'b1;
        end else begin
          result[i*BCD_W +: BCD_W] = t[BCD_W-1:0];
          c = 1'b0;
        end
      end else begin
        t = {1'b0, d} - {{BCD_W{1'b0}}, one} - {{BCD_W{1'b0}}, c};
        // a set top bit means the digit went negative: wrap by +10 and borrow
        if (t[BCD_W]) begin
          result[i*BCD_W +: BCD_W] = BCD_W'(t + (BCD_W+1)'(10));
          c = 1'b1;
        end else begin
          result[i*BCD_W +: BCD_W] = t[BCD_W-1:0];
          c = 1'b0;
        end
      end
    end
    ovf = c;
  end

endmodule

// File: rtl/freq_set_ctrl.sv
// Key-driven BCD frequency setpoint with saturation, sequential BCD-to-binary
// conversion and a one-cycle publish strobe towards the generator.
//
// state   | meaning
// IDLE    | waiting; takes the pending slot first, else the registered key command
// APPLY   | step the BCD setpoint by +/-10^k with clamping
// CONV    | one BCD digit per cycle into acc, MSB first
// PUBLISH | copy acc to freq_out, strobe freq_valid next cycle
module freq_set_ctrl
  import freq_ctrl_pkg::*;
#(
  parameter int DIGITS       = 6,
  parameter int COARSE_DIGIT = 4,
  parameter int FREQ_W       = 32,
  parameter int FREQ_MIN     = 1,
  parameter int FREQ_MAX     = 999999,
  parameter int FREQ_RST     = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc_fine,
  input  logic                    dec_fine,
  input  logic                    inc_coarse,
  input  logic                    dec_coarse,
  output logic [BCD_W*DIGITS-1:0] bcd_digits,
  output logic [FREQ_W-1:0]       freq_out,
  output logic                    freq_valid,
  output logic                    busy
);

  localparam int BW    = BCD_W*DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [BCD_W*BCD_MAX_DIGITS-1:0] MIN_FULL = bcd_min(FREQ_MIN);
  localparam logic [BCD_W*BCD_MAX_DIGITS-1:0] MAX_FULL = bcd_max(FREQ_MAX);
  localparam logic [BCD_W*BCD_MAX_DIGITS-1:0] RST_FULL = bcd_rst(FREQ_RST);
  localparam logic [BW-1:0] BCD_MIN = MIN_FULL[BW-1:0];
  localparam logic [BW-1:0] BCD_MAX = MAX_FULL[BW-1:0];
  localparam logic [BW-1:0] BCD_RST = RST_FULL[BW-1:0];

  state_t             state, state_nxt;
  cmd_t               cmd_in, cmd_r, cmd_q, pend_cmd;
  logic               pend_valid;
  logic [BW-1:0]      bcd_q, cand, bcd_next;
  logic               cand_ovf;
  logic               step_sub;
  logic [IDX_W-1:0]   step_k;
  logic [IDX_W-1:0]   idx;
  logic [FREQ_W-1:0]  acc, freq_q;
  logic               valid_q;
  logic [BCD_W-1:0]   digit;

  // Simultaneous keys are treated as no command at all.
  always_comb begin
    cmd_in = NONE;
    case ({inc_fine, dec_fine, inc_coarse, dec_coarse})
      4'b1000: cmd_in = INC_F;
      4'b0100: cmd_in = DEC_F;
      4'b0010: cmd_in = INC_C;
      4'b0001: cmd_in = DEC_C;
      default: cmd_in = NONE;
    endcase
  end

  assign step_sub = (cmd_q == DEC_F) || (cmd_q == DEC_C);
  assign step_k   = ((cmd_q == INC_C) || (cmd_q == DEC_C)) ? IDX_W'(COARSE_DIGIT) : '0;

  bcd_step_addsub #(.DIGITS(DIGITS), .IDX_W(IDX_W)) u_step (
    .din    (bcd_q),
    .k      (step_k),
    .sub    (step_sub),
    .result (cand),
    .ovf    (cand_ovf)
  );

  // BCD words compare correctly as plain unsigned numbers.
  always_comb begin
    bcd_next = cand;
    if (!step_sub && (cand_ovf || (cand > BCD_MAX)))
      bcd_next = BCD_MAX;
    else if (step_sub && (cand_ovf || (cand < BCD_MIN)))
      bcd_next = BCD_MIN;
  end

  assign digit = bcd_q[int'(idx)*BCD_W +: BCD_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend_valid || (cmd_r != NONE)) state_nxt = APPLY;
      APPLY:   state_nxt = CONV;
      CONV:    if (idx == '0) state_nxt = PUBLISH;
      PUBLISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r      <= NONE;
      cmd_q      <= NONE;
      pend_cmd   <= NONE;
      pend_valid <= 1'b0;
      bcd_q      <= BCD_RST;
      acc        <= '0;
      idx        <= '0;
      freq_q     <= FREQ_W'(FREQ_RST);
      valid_q    <= 1'b0;
    end else begin
      cmd_r   <= cmd_in;
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_valid) begin
            cmd_q      <= pend_cmd;
            pend_valid <= 1'b0;
          end else if (cmd_r != NONE) begin
            cmd_q <= cmd_r;
          end
        end
        APPLY: begin
          bcd_q <= bcd_next;
          acc   <= '0;
          idx   <= IDX_W'(DIGITS-1);
        end
        CONV: begin
          acc <= (acc << 3) + (acc << 1) + FREQ_W'(digit);
          idx <= idx - IDX_W'(1);
        end
        PUBLISH: begin
          freq_q  <= acc;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
      // Only the first command seen while busy is kept.
      if ((state != IDLE) && (cmd_r != NONE) && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_cmd   <= cmd_r;
      end
    end
  end

  assign bcd_digits = bcd_q;
  assign freq_out   = freq_q;
  assign freq_valid = valid_q;
  assign busy       = (state != IDLE);

endmodule
